// File: rtl/rail_crossing_multi_ctrl.sv
// ============================================================================
//  rail_crossing_multi_ctrl
//  Multi-track road-crossing controller: pre-warning, timed gate travel,
//  clear-hold delay and flashing warning lamps.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module rail_crossing_multi_ctrl #(
  parameter int NUM_TRACKS        = 2,
  parameter int PRE_WARN_CYCLES   = 20,
  parameter int GATE_MOVE_CYCLES  = 10,
  parameter int CLEAR_HOLD_CYCLES = 30,
  parameter int FLASH_HALF        = 4,
  parameter int CNT_W             = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_TRACKS-1:0] train_detected,
  output logic                  gate_open,
  output logic                  gate_lower,
  output logic                  gate_raise,
  output logic                  lights_on,
  output logic [NUM_TRACKS-1:0] tracks_busy,
  output logic [2:0]            state_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WARN     = 3'd1,
    S_LOWERING = 3'd2,
    S_CLOSED   = 3'd3,
    S_RAISING  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] C_WARN_LAST  = CNT_W'(PRE_WARN_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_MOVE_LAST  = CNT_W'(GATE_MOVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_HOLD_LAST  = CNT_W'(CLEAR_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_FLASH_LAST = CNT_W'(FLASH_HALF - 1);

  state_t                r_state;
  logic [CNT_W-1:0]      r_timer;
  logic [CNT_W-1:0]      r_flash_cnt;
  logic                  r_gate_open;
  logic                  r_gate_lower;
  logic                  r_gate_raise;
  logic                  r_lights;
  logic [NUM_TRACKS-1:0] r_tracks_busy;

  state_t                w_next_state;
  logic [CNT_W-1:0]      w_next_timer;
  logic [CNT_W-1:0]      w_timer_inc;
  logic [CNT_W-1:0]      w_next_flash;
  logic                  w_next_lights;
  logic                  w_any_train;

  assign w_any_train = |train_detected;
  assign w_timer_inc = (r_timer == {CNT_W{1'b1}}) ? r_timer : r_timer + 1'b1;

  always_comb begin
    w_next_state = r_state;
    w_next_timer = w_timer_inc;
    case (r_state)
      S_IDLE: begin
        w_next_timer = '0;
        if (w_any_train) w_next_state = S_WARN;
      end
      S_WARN: begin
        // detections are ignored here: once warning starts, the gate comes down
        if (r_timer >= C_WARN_LAST) begin
          w_next_state = S_LOWERING;
          w_next_timer = '0;
        end
      end
      S_LOWERING: begin
        if (r_timer >= C_MOVE_LAST) begin
          w_next_state = S_CLOSED;
          w_next_timer = '0;
        end
      end
      S_CLOSED: begin
        if (w_any_train) begin
          w_next_timer = '0;
        end else if (r_timer >= C_HOLD_LAST) begin
          w_next_state = S_RAISING;
          w_next_timer = '0;
        end
      end
      S_RAISING: begin
        // a new train reverses the gate with a full travel time
        if (w_any_train) begin
          w_next_state = S_LOWERING;
          w_next_timer = '0;
        end else if (r_timer >= C_MOVE_LAST) begin
          w_next_state = S_IDLE;
          w_next_timer = '0;
        end
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_timer = '0;
      end
    endcase
  end

  always_comb begin
    w_next_flash  = r_flash_cnt + 1'b1;
    w_next_lights = r_lights;
    if (w_next_state == S_IDLE) begin
      w_next_flash  = '0;
      w_next_lights = 1'b0;
    end else if (r_state == S_IDLE) begin
      w_next_flash  = '0;
      w_next_lights = 1'b1;
    end else if (r_flash_cnt >= C_FLASH_LAST) begin
      w_next_flash  = '0;
      w_next_lights = ~r_lights;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_timer       <= '0;
      r_flash_cnt   <= '0;
      r_gate_open   <= 1'b1;
      r_gate_lower  <= 1'b0;
      r_gate_raise  <= 1'b0;
      r_lights      <= 1'b0;
      r_tracks_busy <= '0;
    end else begin
      r_state       <= w_next_state;
      r_timer       <= w_next_timer;
      r_flash_cnt   <= w_next_flash;
      r_gate_open   <= (w_next_state == S_IDLE) || (w_next_state == S_WARN);
      r_gate_lower  <= (w_next_state == S_LOWERING);
      r_gate_raise  <= (w_next_state == S_RAISING);
      r_lights      <= w_next_lights;
      r_tracks_busy <= train_detected;
    end
  end

  assign gate_open   = r_gate_open;
  assign gate_lower  = r_gate_lower;
  assign gate_raise  = r_gate_raise;
  assign lights_on   = r_lights;
  assign tracks_busy = r_tracks_busy;
  assign state_o     = r_state;

endmodule

`default_nettype wire

// File: tb/tb_rail_crossing_multi_ctrl.sv
// ============================================================================
//  tb_rail_crossing_multi_ctrl
//  Directed, table-driven bench for the multi-track crossing controller.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rail_crossing_multi_ctrl;

  localparam int NT = 2;
  localparam int FH = 4;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_WARN = 3'd1, ST_LOW = 3'd2,
                         ST_CLOSED = 3'd3, ST_RAISE = 3'd4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NT-1:0] train_detected;
  logic          gate_open, gate_lower, gate_raise, lights_on;
  logic [NT-1:0] tracks_busy;
  logic [2:0]    state_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] train;
    int         cycles;
    logic [2:0] st;
  } vec_t;

  vec_t tbl[$];

  rail_crossing_multi_ctrl #(
    .NUM_TRACKS(NT), .PRE_WARN_CYCLES(20), .GATE_MOVE_CYCLES(10),
    .CLEAR_HOLD_CYCLES(30), .FLASH_HALF(FH), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .train_detected(train_detected),
    .gate_open(gate_open), .gate_lower(gate_lower), .gate_raise(gate_raise),
    .lights_on(lights_on), .tracks_busy(tracks_busy), .state_o(state_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    checks++;
    if (gate_lower && gate_raise) begin
      errors++;
      $display("FAIL lower_raise_excl at %0t: lower=%0b raise=%0b required not both 1",
               $time, gate_lower, gate_raise);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h required %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [1:0] t, input int n, input logic [2:0] s);
    vec_t v;
    v.train  = t;
    v.cycles = n;
    v.st     = s;
    tbl.push_back(v);
  endtask

  // tracks_busy must equal the input applied before the last edge, which the
  // bench still holds in train_detected at check time
  task automatic chk_outputs(input logic [2:0] st, input logic lit, input string tag);
    chk({tag, ".state"},      32'(state_o),     32'(st));
    chk({tag, ".gate_open"},  32'(gate_open),   32'((st == ST_IDLE) || (st == ST_WARN)));
    chk({tag, ".gate_lower"}, 32'(gate_lower),  32'(st == ST_LOW));
    chk({tag, ".gate_raise"}, 32'(gate_raise),  32'(st == ST_RAISE));
    chk({tag, ".lights"},     32'(lights_on),   32'(lit));
    chk({tag, ".busy"},       32'(tracks_busy), 32'(train_detected));
  endtask

  initial begin
    int         age;
    logic [2:0] prev;
    logic       lit;

    reset = 1'b1;
    train_detected = '0;
    repeat (2) tick;
    chk_outputs(ST_IDLE, 1'b0, "reset");
    #2 reset = 1'b0;
    tick;

    // single pulse: full WARN/LOWERING/CLOSED/RAISING cycle
    add(2'b01, 1, ST_IDLE);   add(2'b00, 20, ST_WARN);  add(2'b00, 10, ST_LOW);
    add(2'b00, 30, ST_CLOSED); add(2'b00, 10, ST_RAISE); add(2'b00, 5, ST_IDLE);
    // overlapping trains on both tracks
    add(2'b01, 1, ST_IDLE);   add(2'b01, 20, ST_WARN);  add(2'b01, 10, ST_LOW);
    add(2'b01, 19, ST_CLOSED); add(2'b11, 50, ST_CLOSED); add(2'b10, 50, ST_CLOSED);
    add(2'b00, 30, ST_CLOSED); add(2'b00, 10, ST_RAISE); add(2'b00, 5, ST_IDLE);
    // re-detection at hold count 25 restarts the clear hold
    add(2'b01, 1, ST_IDLE);   add(2'b00, 20, ST_WARN);  add(2'b00, 10, ST_LOW);
    add(2'b00, 25, ST_CLOSED); add(2'b01, 1, ST_CLOSED); add(2'b00, 30, ST_CLOSED);
    add(2'b00, 10, ST_RAISE); add(2'b00, 5, ST_IDLE);
    // detection on RAISING cycle 5 reverses with a full lowering
    add(2'b01, 1, ST_IDLE);   add(2'b00, 20, ST_WARN);  add(2'b00, 10, ST_LOW);
    add(2'b00, 30, ST_CLOSED); add(2'b00, 5, ST_RAISE); add(2'b10, 1, ST_RAISE);
    add(2'b00, 10, ST_LOW);   add(2'b00, 30, ST_CLOSED); add(2'b00, 10, ST_RAISE);
    add(2'b00, 5, ST_IDLE);

    age  = 0;
    prev = ST_IDLE;
    for (int i = 0; i < tbl.size(); i++) begin
      for (int c = 0; c < tbl[i].cycles; c++) begin
        if (tbl[i].st == ST_WARN && prev == ST_IDLE) age = 0;
        else age++;
        prev = tbl[i].st;
        lit = (tbl[i].st != ST_IDLE) && (((age / FH) % 2) == 0);
        chk_outputs(tbl[i].st, lit, $sformatf("vec%0d_c%0d", i, c));
        train_detected = tbl[i].train;
        tick;
      end
    end

    // asynchronous reset while CLOSED with track 0 occupied
    train_detected = 2'b01;
    tick;
    repeat (35) tick;
    chk("pre_reset.state", 32'(state_o), 32'(ST_CLOSED));
    #2 reset = 1'b1;
    #1;
    chk("async_reset.state",  32'(state_o),     32'(ST_IDLE));
    chk("async_reset.open",   32'(gate_open),   32'd1);
    chk("async_reset.lights", 32'(lights_on),   32'd0);
    chk("async_reset.lower",  32'(gate_lower),  32'd0);
    chk("async_reset.busy",   32'(tracks_busy), 32'd0);
    train_detected = 2'b00;
    tick;
    #2 reset = 1'b0;
    tick;
    chk_outputs(ST_IDLE, 1'b0, "post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
